serial_subtractor: RTL and testbench

Bit-serial, LSB-first subtractor computing diff = a - b - borrow_in over WIDTH clock cycles with one 1-bit full-subtractor cell. It is the subtract-direction counterpart of the adder datapath in the SAP-1 ALU area and trades area for latency. Operands are captured on a start handshake. The result, borrow and zero flag are held until the next accepted start.

---
 rtl/sap_alu_pkg.sv | 14 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_alu_pkg.sv
// Shared types and constants for the SAP-1 ALU datapath blocks.
package sap_alu_pkg;

   // Widest operand any serial ALU cell in this area is built for.
   localparam int unsigned SUB_MAX_WIDTH = 32;

   // Serial subtractor control states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow into the next bit.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - borrow_in over WIDTH cycles using
// a single full_subtractor cell. Result, borrow and zero flag hold until the next start.
module serial_subtractor
   import sap_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   sub_state_e state_q, state_d;

   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             borrow_out_q, borrow_out_d;
   logic             zero_q, zero_d;

   logic             cell_d;
   logic             cell_bout;
   logic             last_bit;
   logic [WIDTH-1:0] res_shifted;

   full_subtractor u_cell (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (brw_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last_bit    = (cnt_q == CntLast);
   // New bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
   assign res_shifted = {cell_d, res_q[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start only honoured in idle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StShift;
         StShift: if (last_bit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs: status decoded from the state register, results from holding registers.
   always_comb begin
      busy       = (state_q == StShift);
      done       = (state_q == StDone);
      diff       = diff_q;
      borrow_out = borrow_out_q;
      zero       = zero_q;
   end

   // Datapath next-state: capture on accept, shift one bit per cycle, latch result on last bit.
   always_comb begin
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      res_d        = res_q;
      cnt_d        = cnt_q;
      brw_d        = brw_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
      zero_d       = zero_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_sh_d = a;
               b_sh_d = b;
               brw_d  = borrow_in;
               cnt_d  = '0;
            end
         end
         StShift: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            brw_d  = cell_bout;
            res_d  = res_shifted;
            cnt_d  = cnt_q + 1'b1;
            if (last_bit) begin
               diff_d       = res_shifted;
               borrow_out_d = cell_bout;
               zero_d       = (res_shifted == '0);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         res_q        <= '0;
         cnt_q        <= '0;
         brw_q        <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         zero_q       <= 1'b0;
      end else begin
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         res_q        <= res_d;
         cnt_q        <= cnt_d;
         brw_q        <= brw_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         zero_q       <= zero_d;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: 8-bit vector table plus corner sequences,
// and an exhaustive 4-bit sweep with start held high.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 8-bit instance
   logic       rst8, start8, bin8, busy8, done8, bout8, zero8;
   logic [7:0] a8, b8, diff8;

   // 4-bit instance
   logic       rst4, start4, bin4, busy4, done4, bout4, zero4;
   logic [3:0] a4, b4, diff4;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .rst        (rst8),
      .start      (start8),
      .a          (a8),
      .b          (b8),
      .borrow_in  (bin8),
      .busy       (busy8),
      .done       (done8),
      .diff       (diff8),
      .borrow_out (bout8),
      .zero       (zero8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk        (clk),
      .rst        (rst4),
      .start      (start4),
      .a          (a4),
      .b          (b4),
      .borrow_in  (bin4),
      .busy       (busy4),
      .done       (done4),
      .diff       (diff4),
      .borrow_out (bout4),
      .zero       (zero4)
   );

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
      logic       zero;
   } exp8_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       zero;
   } vec_t;

   exp8_t      q8[$];
   logic [4:0] q4[$];
   exp8_t      mon_e;
   vec_t       vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: unsigned a - b - bin at 4 bits, returns {borrow, diff}.
   function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int t;
      logic [31:0] tv;
      t  = int'(a) - int'(b) - int'(bin);
      tv = t;
      return {(t < 0), tv[3:0]};
   endfunction

   // Scoreboard for the 8-bit instance: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (rst8 === 1'b0 && done8 === 1'b1) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut8_spurious_done: got done=1 expected done=0");
         end else begin
            mon_e = q8.pop_front();
            check("dut8_diff", 32'(diff8), 32'(mon_e.diff));
            check("dut8_borrow_out", 32'(bout8), 32'(mon_e.bout));
            check("dut8_zero", 32'(zero8), 32'(mon_e.zero));
         end
      end
   end

   // Drive one operation from an idle negedge; returns at the idle negedge after done.
   task automatic do_op8(input vec_t v, input string tag);
      int n;
      int nb;
      q8.push_back('{diff: v.diff, bout: v.bout, zero: v.zero});
      a8     = v.a;
      b8     = v.b;
      bin8   = v.bin;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      // Operand changes after acceptance must not matter.
      a8   = ~v.a;
      b8   = ~v.b;
      bin8 = ~v.bin;
      n  = 0;
      nb = 0;
      while (done8 !== 1'b1 && n < 40) begin
         if (busy8 === 1'b1) nb++;
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd8);
      check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
      @(negedge clk);
      check({tag, "_done_pulse_width"}, 32'(done8), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected simulation end");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int dn;
      logic [4:0] e4;

      rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

      vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, diff: 8'h02, bout: 1'b0, zero: 1'b0};
      vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, diff: 8'hFE, bout: 1'b1, zero: 1'b0};
      vecs[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1, zero: 1'b0};
      vecs[3] = '{a: 8'h7A, b: 8'h7A, bin: 1'b0, diff: 8'h00, bout: 1'b0, zero: 1'b1};
      vecs[4] = '{a: 8'hFF, b: 8'h00, bin: 1'b1, diff: 8'hFE, bout: 1'b0, zero: 1'b0};
      vecs[5] = '{a: 8'h00, b: 8'hFF, bin: 1'b0, diff: 8'h01, bout: 1'b1, zero: 1'b0};
      vecs[6] = '{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, zero: 1'b0};
      vecs[7] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, diff: 8'hFF, bout: 1'b1, zero: 1'b0};

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_diff", 32'(diff8), 32'd0);
      check("rst_borrow_out", 32'(bout8), 32'd0);
      check("rst_zero", 32'(zero8), 32'd0);

      // Reset and start together: reset must win.
      start8 = 1'b1;
      a8     = 8'h12;
      @(negedge clk);
      check("rst_beats_start_busy", 32'(busy8), 32'd0);
      start8 = 1'b0;
      rst8   = 1'b0;
      rst4   = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         do_op8(vecs[i], $sformatf("vec%0d", i));
      end

      // Second start during SHIFT is ignored.
      q8.push_back('{diff: 8'h0F, bout: 1'b0, zero: 1'b0});
      a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      repeat (2) begin
         @(negedge clk);
         n++;
      end
      a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
      @(negedge clk);
      n++;
      start8 = 1'b0;
      while (done8 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ignore_latency", 32'(n), 32'd8);
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 === 1'b1) dn++;
      end
      check("ignore_no_second_done", 32'(dn), 32'd0);

      // Leave a borrowing result in the output registers before the abort test.
      do_op8('{a: 8'h00, b: 8'h01, bin: 1'b0, diff: 8'hFF, bout: 1'b1, zero: 1'b0}, "pre_abort");

      // Reset in SHIFT cycle 4 aborts with no done pulse.
      a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before_rst", 32'(busy8), 32'd1);
      rst8 = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_done", 32'(done8), 32'd0);
      check("abort_diff", 32'(diff8), 32'd0);
      check("abort_borrow_out", 32'(bout8), 32'd0);
      check("abort_zero", 32'(zero8), 32'd0);
      rst8 = 1'b0;
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 === 1'b1) dn++;
      end
      check("abort_no_done", 32'(dn), 32'd0);

      // Exhaustive 4-bit sweep, start held high: results every 6 cycles.
      begin
         logic [8:0] idx;
         idx  = 9'd0;
         a4   = idx[3:0];
         b4   = idx[7:4];
         bin4 = idx[8];
         q4.push_back(ref4(idx[3:0], idx[7:4], idx[8]));
         start4 = 1'b1;
         for (int k = 0; k < 512; k++) begin
            n = 0;
            while (done4 !== 1'b1 && n < 40) begin
               @(negedge clk);
               n++;
            end
            if (done4 !== 1'b1) begin
               check("sweep_timeout", 32'(done4), 32'd1);
               break;
            end
            if (k > 0) check($sformatf("sweep%0d_done_spacing", k), 32'(n + 1), 32'd6);
            e4 = q4.pop_front();
            check($sformatf("sweep%0d_diff", k), 32'(diff4), 32'(e4[3:0]));
            check($sformatf("sweep%0d_borrow_out", k), 32'(bout4), 32'(e4[4]));
            check($sformatf("sweep%0d_zero", k), 32'(zero4), 32'(e4[3:0] == 4'd0));
            if (k < 511) begin
               idx  = 9'(k + 1);
               a4   = idx[3:0];
               b4   = idx[7:4];
               bin4 = idx[8];
               q4.push_back(ref4(idx[3:0], idx[7:4], idx[8]));
            end else begin
               start4 = 1'b0;
            end
            @(negedge clk);
         end
      end

      check("dut8_queue_drained", 32'(q8.size()), 32'd0);
      check("dut4_queue_drained", 32'(q4.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
